// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
//   lsu_type_e  : access size encoding used on lsu_type_i
//   lsu_state_e : FSM state encoding (mirrors the ST_* constants)
//   lsu_req_t   : fields of an accepted request that the LSU still needs
//                 after the accept edge
package lsu_pkg;

   typedef enum logic [1:0] {
      BYTE    = 2'b00,
      HALF    = 2'b01,
      WORD    = 2'b10,
      ILLEGAL = 2'b11
   } lsu_type_e;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } lsu_state_e;

   // The word part of the address lives in the data_addr_o register and the
   // store data in the data_wdata_o register, so only the byte offset is kept.
   typedef struct packed {
      logic      we;
      lsu_type_e typ;
      logic      sign_ext;
      logic [1:0] addr_lo;
   } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Inputs : typ (access size), addr_lo (byte offset), wdata (right-aligned
//          store data), rdata_raw (memory word), sign_ext (load extension)
// Outputs: sel (byte lanes), wdata_rep (lane-replicated store data),
//          rdata_ext (extracted, extended load data), misaligned (request
//          is illegal: bad size or bad alignment)
module lsu_align
   import lsu_pkg::*;
(
   input  lsu_type_e   typ,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_raw,
   input  logic        sign_ext,
   output logic [3:0]  sel,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [31:0] shifted;

   always_comb begin
      shifted   = rdata_raw >> {addr_lo, 3'b000};
      sel       = 4'b0000;
      wdata_rep = wdata;
      rdata_ext = 32'h0;
      case (typ)
         BYTE: begin
            sel       = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
         end
         HALF: begin
            sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
         end
         WORD: begin
            sel       = 4'b1111;
            rdata_ext = shifted;
         end
         default: begin
            sel       = 4'b0000;
         end
      endcase
   end

   // The illegal size code is folded in so one flag decides the error path.
   assign misaligned = (typ == ILLEGAL)
                     | ((typ == HALF) & addr_lo[0])
                     | ((typ == WORD) & (addr_lo != 2'b00));

endmodule

// File: rtl/lsu.sv
// Load/store unit: initiator side of the data-memory port.
// Request side : lsu_req_i/lsu_we_i/lsu_type_i/lsu_sign_ext_i/lsu_addr_i/
//                lsu_wdata_i in; lsu_busy_o, lsu_rvalid_o, lsu_rdata_o,
//                lsu_err_o out.
// Memory side  : data_ce_o, data_wr_en_o, data_sel_o, data_addr_o,
//                data_wdata_o out; data_rdata_i, data_rvalid_i in.
// Debug        : dbg_state_o exposes the FSM state (ST_* encoding).
//
// Handshake: a request is taken on a rising edge where lsu_req_i=1 and
// lsu_busy_o=0; the requester holds it until then, requests seen while busy
// are dropped. Each accepted request yields exactly one lsu_rvalid_o pulse
// (with lsu_err_o for rejected requests) unless reset intervenes.
module lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [1:0]        lsu_type_i,
   input  logic              lsu_sign_ext_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [31:0]       lsu_wdata_i,
   output logic              lsu_busy_o,
   output logic              lsu_rvalid_o,
   output logic [31:0]       lsu_rdata_o,
   output logic              lsu_err_o,
   output logic              data_ce_o,
   output logic              data_wr_en_o,
   output logic [3:0]        data_sel_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   input  logic [31:0]       data_rdata_i,
   input  logic              data_rvalid_i,
   output logic [1:0]        dbg_state_o
);

   logic [1:0]  state;
   lsu_req_t    req_q;

   lsu_type_e   a_typ;
   logic [1:0]  a_addr_lo;
   logic [3:0]  a_sel;
   logic [31:0] a_wdata;
   logic [31:0] a_rdata;
   logic        a_mis;

   // One lane unit serves both phases: in IDLE it decodes the incoming
   // request, afterwards it extracts load data using the latched request.
   assign a_typ     = (state == ST_IDLE) ? lsu_type_e'(lsu_type_i) : req_q.typ;
   assign a_addr_lo = (state == ST_IDLE) ? lsu_addr_i[1:0] : req_q.addr_lo;

   lsu_align u_align (
      .typ        (a_typ),
      .addr_lo    (a_addr_lo),
      .wdata      (lsu_wdata_i),
      .rdata_raw  (data_rdata_i),
      .sign_ext   (req_q.sign_ext),
      .sel        (a_sel),
      .wdata_rep  (a_wdata),
      .rdata_ext  (a_rdata),
      .misaligned (a_mis)
   );

   assign lsu_busy_o  = (state != ST_IDLE);
   assign dbg_state_o = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         req_q        <= '0;
         lsu_rvalid_o <= 1'b0;
         lsu_rdata_o  <= 32'h0;
         lsu_err_o    <= 1'b0;
         data_ce_o    <= 1'b0;
         data_wr_en_o <= 1'b0;
         data_sel_o   <= 4'b0000;
         data_addr_o  <= '0;
         data_wdata_o <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               lsu_rvalid_o <= 1'b0;
               lsu_err_o    <= 1'b0;
               lsu_rdata_o  <= 32'h0;
               if (lsu_req_i) begin
                  req_q <= '{we: lsu_we_i, typ: lsu_type_e'(lsu_type_i),
                             sign_ext: lsu_sign_ext_i, addr_lo: lsu_addr_i[1:0]};
                  if (a_mis) begin
                     // Rejected: respond directly, bus never touched.
                     state        <= ST_RESP;
                     lsu_rvalid_o <= 1'b1;
                     lsu_err_o    <= 1'b1;
                  end else begin
                     state        <= ST_ACCESS;
                     data_ce_o    <= 1'b1;
                     data_wr_en_o <= lsu_we_i;
                     data_sel_o   <= a_sel;
                     data_addr_o  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
                     data_wdata_o <= lsu_we_i ? a_wdata : 32'h0;
                  end
               end
            end
            ST_ACCESS: begin
               // Stores finish after one bus cycle; loads wait for rvalid
               // with every bus output left untouched.
               if (req_q.we || data_rvalid_i) begin
                  state        <= ST_RESP;
                  lsu_rvalid_o <= 1'b1;
                  lsu_rdata_o  <= req_q.we ? 32'h0 : a_rdata;
                  data_ce_o    <= 1'b0;
                  data_wr_en_o <= 1'b0;
                  data_sel_o   <= 4'b0000;
                  data_addr_o  <= '0;
                  data_wdata_o <= 32'h0;
               end
            end
            ST_RESP: begin
               state        <= ST_IDLE;
               lsu_rvalid_o <= 1'b0;
               lsu_err_o    <= 1'b0;
               lsu_rdata_o  <= 32'h0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a small word memory answers the data port, the
// drivers push the expected response of every request into exp_q, and an
// independent monitor pops and compares on every lsu_rvalid_o pulse.
module tb_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
   logic [1:0]  lsu_type_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_busy_o, lsu_rvalid_o, lsu_err_o;
   logic [31:0] lsu_rdata_o;
   logic        data_ce_o, data_wr_en_o;
   logic [3:0]  data_sel_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic        data_rvalid_i;
   logic [1:0]  dbg_state_o;

   logic        rv_en;
   logic        mem_init;
   logic [31:0] mem [0:255];

   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   lsu #(.ADDR_W(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
      .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_busy_o(lsu_busy_o),
      .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .lsu_err_o(lsu_err_o), .data_ce_o(data_ce_o),
      .data_wr_en_o(data_wr_en_o), .data_sel_o(data_sel_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_rdata_i(data_rdata_i), .data_rvalid_i(data_rvalid_i),
      .dbg_state_o(dbg_state_o)
   );

   // Memory model: lane-masked write at the end of a bus cycle, held off
   // while reset is asserted; read data valid only when enabled by the bench.
   assign data_rdata_i  = mem[data_addr_o[9:2]];
   assign data_rvalid_i = data_ce_o & ~data_wr_en_o & rv_en;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[64] <= 32'h1122_3344;   // 0x100
         mem[66] <= 32'hCAFE_F00D;   // 0x108
         mem[67] <= 32'h5566_7788;   // 0x10C
      end else if (data_ce_o && data_wr_en_o && !rst_i) begin
         for (int b = 0; b < 4; b++)
            if (data_sel_o[b]) mem[data_addr_o[9:2]][8*b +: 8] <= data_wdata_o[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst_i) begin
         if (lsu_rvalid_o) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_resp: got err=%b rdata=%h, expected no response",
                        lsu_err_o, lsu_rdata_o);
            end else begin
               check("resp", {lsu_err_o, lsu_rdata_o}, exp_q.pop_front());
            end
         end else if (lsu_err_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL err_without_rvalid: got err=1, expected 0");
         end
      end
   end

   // Drive one request; returns at the negedge of the cycle after acceptance.
   task automatic issue(input logic we, input logic [1:0] typ, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int k = 0;
      while (lsu_busy_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL busy_timeout: busy still 1, expected 0");
      end
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ;
      lsu_sign_ext_i = sext; lsu_addr_i = addr; lsu_wdata_i = wdata;
      @(negedge clk);
      lsu_req_i = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((lsu_busy_o || exp_q.size() != 0) && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         n_checks++;
         n_errors++;
         $display("FAIL resp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic do_store(input logic [1:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] exp_sel,
                           input logic [31:0] exp_wdata);
      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, typ, 1'b0, addr, wdata);
      check("st_ce",     {32'h0, data_ce_o},      33'd1);
      check("st_wr",     {32'h0, data_wr_en_o},   33'd1);
      check("st_sel",    {29'h0, data_sel_o},     {29'h0, exp_sel});
      check("st_wdata",  {1'b0, data_wdata_o},    {1'b0, exp_wdata});
      check("st_addr",   {1'b0, data_addr_o},     {1'b0, addr & 32'hFFFF_FFFC});
      check("st_early",  {32'h0, lsu_rvalid_o},   33'd0);
      @(negedge clk);
      check("st_rvalid", {32'h0, lsu_rvalid_o},   33'd1);
      check("st_wr_off", {31'h0, data_ce_o, data_wr_en_o}, 33'd0);
      wait_idle();
   endtask

   task automatic do_load(input logic [1:0] typ, input logic sext,
                          input logic [31:0] addr, input logic [31:0] exp_data);
      exp_q.push_back({1'b0, exp_data});
      issue(1'b0, typ, sext, addr, 32'h0);
      check("ld_bus",  {31'h0, data_ce_o, data_wr_en_o}, 33'b10);
      check("ld_addr", {1'b0, data_addr_o}, {1'b0, addr & 32'hFFFF_FFFC});
      wait_idle();
   endtask

   task automatic do_err(input logic we, input logic [1:0] typ, input logic [31:0] addr);
      exp_q.push_back({1'b1, 32'h0});
      issue(we, typ, 1'b1, addr, 32'h1234_5678);
      check("err_pulse", {31'h0, lsu_rvalid_o, lsu_err_o}, 33'b11);
      check("err_ce",    {32'h0, data_ce_o}, 33'd0);
      @(negedge clk);
      check("err_ce2",   {32'h0, data_ce_o}, 33'd0);
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; mem_init = 1'b1; rv_en = 1'b1;
      lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_type_i = 2'b00;
      lsu_sign_ext_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      check("rst_outs", {lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_ce_o,
                         data_wr_en_o, data_sel_o, dbg_state_o}, {22'h0, 9'h0, ST_IDLE});
      check("rst_data", {1'b0, lsu_rdata_o | data_addr_o | data_wdata_o}, 33'h0);
      rst_i = 1'b0;
      @(negedge clk);

      // Byte store into the top lane, then read the whole word back.
      do_store(2'b00, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
      do_load (2'b10, 1'b0, 32'h0000_0100, 32'hAB22_3344);

      // Half loads with sign and zero extension.
      do_store(2'b10, 32'h0000_0100, 32'h8001_1234, 4'b1111, 32'h8001_1234);
      do_load (2'b01, 1'b1, 32'h0000_0102, 32'hFFFF_8001);
      do_load (2'b01, 1'b0, 32'h0000_0102, 32'h0000_8001);

      // Byte load signed, word load ignores sign_ext.
      do_store(2'b10, 32'h0000_0100, 32'h0000_F500, 4'b1111, 32'h0000_F500);
      do_load (2'b00, 1'b1, 32'h0000_0101, 32'hFFFF_FFF5);
      do_load (2'b10, 1'b1, 32'h0000_0100, 32'h0000_F500);

      // Upper half store and extraction from the top lanes.
      do_store(2'b01, 32'h0000_0106, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF);
      do_load (2'b10, 1'b0, 32'h0000_0104, 32'hBEEF_0000);
      do_load (2'b00, 1'b0, 32'h0000_0107, 32'h0000_00BE);
      do_load (2'b01, 1'b1, 32'h0000_0106, 32'hFFFF_BEEF);

      // Rejected requests.
      do_err(1'b0, 2'b10, 32'h0000_0106);
      do_err(1'b0, 2'b11, 32'h0000_0100);
      do_err(1'b1, 2'b01, 32'h0000_0101);

      // Stalled load with a request pulsed while busy.
      rv_en = 1'b0;
      exp_q.push_back({1'b0, 32'hCAFE_F00D});
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         check("stall_ce",   {32'h0, data_ce_o},    33'd1);
         check("stall_addr", {1'b0, data_addr_o},   {1'b0, 32'h0000_0108});
         check("stall_rv",   {32'h0, lsu_rvalid_o}, 33'd0);
         if (c == 2) begin
            lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_type_i = 2'b10;
            lsu_addr_i = 32'h0000_010C; lsu_wdata_i = 32'h0;
         end
         if (c == 3) lsu_req_i = 1'b0;
         if (c == 4) rv_en = 1'b1;
         if (c < 4) @(negedge clk);
      end
      @(negedge clk);
      check("stall_resp", {32'h0, lsu_rvalid_o}, 33'd1);
      wait_idle();
      repeat (3) @(negedge clk);
      check("ignored_req", {32'h0, lsu_busy_o}, 33'd0);

      // Reset during the bus cycle of a store.
      issue(1'b1, 2'b10, 1'b0, 32'h0000_010C, 32'hDEAD_BEEF);
      check("abort_ce", {32'h0, data_ce_o}, 33'd1);
      rst_i = 1'b1;
      @(negedge clk);
      check("abort_outs", {lsu_busy_o, lsu_rvalid_o, lsu_err_o, data_ce_o,
                           data_wr_en_o, data_sel_o, dbg_state_o}, {22'h0, 9'h0, ST_IDLE});
      check("abort_data", {1'b0, lsu_rdata_o | data_addr_o | data_wdata_o}, 33'h0);
      rst_i = 1'b0;
      @(negedge clk);
      do_load(2'b10, 1'b0, 32'h0000_010C, 32'h5566_7788);

      wait_idle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
